inv_rct_stream: RTL and testbench

Two-pixel-per-cycle inverse reversible colour transform (RCT). It converts a frame of Y/Cb/Cr pairs from the decoder back to 8-bit RGB and feeds the display model directly. It drives that stage's RECON_VALID and DATA_RECON_{R,G,B}{0,1} inputs. It paces input with a ready signal, counts pixel pairs per frame, and flags frame completion.

---
 rtl/inv_rct_pkg.sv | 47 ++++
 rtl/inv_rct_stream_if.sv | 51 +++++
 rtl/inv_rct_pixel.sv | 81 ++++++++
 rtl/inv_rct_stream.sv | 120 ++++++++++++
 tb/tb_inv_rct_stream.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_rct_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inv_rct_pkg
//  Purpose  : Shared types, widths and 8-bit reduction helpers for the
//             two-pixel inverse reversible colour transform.
//  Contents : state_t FSM encoding, internal width constants,
//             sat8()    - saturate a signed 11-bit value to 0..255,
//             reduce8() - 8-bit reduction selected by build option.
//  Options  : INV_RCT_CLAMP_EN - when defined, reduce8() saturates;
//             otherwise it keeps bits [7:0] (wraps).
//  Revision : 1.0 - initial release
// ============================================================================
package inv_rct_pkg;

    localparam int c_pix_w    = 8;   // unsigned luma / RGB component width
    localparam int c_chroma_w = 9;   // two's-complement chroma difference
    localparam int c_sum_w    = 10;  // CB + CR
    localparam int c_int_w    = 11;  // G / R / B intermediate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [c_pix_w-1:0] sat8(input logic signed [c_int_w-1:0] v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 11'sd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    function automatic logic [c_pix_w-1:0] reduce8(input logic signed [c_int_w-1:0] v);
`ifdef INV_RCT_CLAMP_EN
        return sat8(v);
`else
        // Legal lossless input always lands in 0..255, so the low byte is exact.
        return v[7:0];
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_rct_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_rct_stream_if
//  Purpose  : Stream bundle between the YCbCr pair source, the inverse RCT
//             block and the RGB display model.
//  Signals  : START, IN_VALID, Y0/Y1, CB0/CR0/CB1/CR1   (source -> block)
//             IN_READY, RECON_VALID, DATA_RECON_*, FRAME_DONE, BUSY
//                                                      (block -> sink)
//  Modports : master - the environment driving pairs / observing RGB
//             slave  - the inverse RCT block
//  Revision : 1.0 - initial release
// ============================================================================
interface inv_rct_stream_if;

    logic       START;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] Y0;
    logic [7:0] Y1;
    logic [8:0] CB0;
    logic [8:0] CR0;
    logic [8:0] CB1;
    logic [8:0] CR1;
    logic       RECON_VALID;
    logic [7:0] DATA_RECON_R0;
    logic [7:0] DATA_RECON_G0;
    logic [7:0] DATA_RECON_B0;
    logic [7:0] DATA_RECON_R1;
    logic [7:0] DATA_RECON_G1;
    logic [7:0] DATA_RECON_B1;
    logic       FRAME_DONE;
    logic       BUSY;

    modport master (
        output START, IN_VALID, Y0, Y1, CB0, CR0, CB1, CR1,
        input  IN_READY, RECON_VALID,
        input  DATA_RECON_R0, DATA_RECON_G0, DATA_RECON_B0,
        input  DATA_RECON_R1, DATA_RECON_G1, DATA_RECON_B1,
        input  FRAME_DONE, BUSY
    );

    modport slave (
        input  START, IN_VALID, Y0, Y1, CB0, CR0, CB1, CR1,
        output IN_READY, RECON_VALID,
        output DATA_RECON_R0, DATA_RECON_G0, DATA_RECON_B0,
        output DATA_RECON_R1, DATA_RECON_G1, DATA_RECON_B1,
        output FRAME_DONE, BUSY
    );

endinterface
`default_nettype wire

// File: rtl/inv_rct_pixel.sv
`default_nettype none
// ============================================================================
//  Module   : inv_rct_pixel
//  Purpose  : One-pixel inverse RCT, two register stages.
//             Stage 1: G = Y - floor((CB + CR) / 4), registers G, CB, CR.
//             Stage 2: R = CR + G, B = CB + G, 8-bit reduction, output regs.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid        - pixel accepted this cycle
//             y, cb, cr       - luma (unsigned 8), chroma (two's comp. 9)
//             out_valid       - r/g/b valid this cycle
//             r, g, b         - reconstructed 8-bit components (held when
//                               out_valid is low)
//  Options  : INV_RCT_CLAMP_EN - saturate instead of wrap (see inv_rct_pkg)
//  Revision : 1.0 - initial release
// ============================================================================
module inv_rct_pixel
    import inv_rct_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  in_valid,
    input  wire logic [c_pix_w-1:0]    y,
    input  wire logic [c_chroma_w-1:0] cb,
    input  wire logic [c_chroma_w-1:0] cr,
    output      logic                  out_valid,
    output      logic [c_pix_w-1:0]    r,
    output      logic [c_pix_w-1:0]    g,
    output      logic [c_pix_w-1:0]    b
);

    logic signed [c_sum_w-1:0]    w_sum;
    logic signed [c_int_w-1:0]    w_g;
    logic signed [c_int_w-1:0]    w_r;
    logic signed [c_int_w-1:0]    w_b;

    logic                         r_v1;
    logic signed [c_int_w-1:0]    r_g1;
    logic signed [c_chroma_w-1:0] r_cb1;
    logic signed [c_chroma_w-1:0] r_cr1;

    // Arithmetic shift of the signed sum gives floor division for negatives.
    assign w_sum = c_sum_w'($signed(cb)) + c_sum_w'($signed(cr));
    assign w_g   = $signed({3'b000, y}) - c_int_w'(w_sum >>> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_g1  <= '0;
            r_cb1 <= '0;
            r_cr1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_g1  <= w_g;
                r_cb1 <= $signed(cb);
                r_cr1 <= $signed(cr);
            end
        end
    end

    assign w_r = r_g1 + c_int_w'(r_cr1);
    assign w_b = r_g1 + c_int_w'(r_cb1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                r <= reduce8(w_r);
                g <= reduce8(r_g1);
                b <= reduce8(w_b);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inv_rct_stream.sv
`default_nettype none
// ============================================================================
//  Module   : inv_rct_stream
//  Purpose  : Two-pixel-per-cycle inverse RCT stream stage. Paces Y/Cb/Cr
//             pairs with IN_READY, counts pairs per frame, converts them to
//             RGB with a fixed 2-cycle latency and pulses FRAME_DONE.
//  Params   : WIDTH  - pixels per line (even)
//             HEIGHT - lines per frame
//  Ports    : HCLK   - clock, rising edge
//             HRESET - synchronous active-high reset (aborts a frame)
//             bus    - inv_rct_stream_if.slave: START, IN_VALID/IN_READY,
//                      Y0/Y1/CB0/CR0/CB1/CR1 in; RECON_VALID,
//                      DATA_RECON_{R,G,B}{0,1}, FRAME_DONE, BUSY out
//  Options  : INV_RCT_CLAMP_EN - saturate RGB to 0..255 instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module inv_rct_stream
    import inv_rct_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  wire logic         HCLK,
    input  wire logic         HRESET,
    inv_rct_stream_if.slave   bus
);

    localparam int c_pairs = WIDTH * HEIGHT / 2;
    localparam int c_cnt_w = (c_pairs > 1) ? $clog2(c_pairs) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_pairs - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_frame_done;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_v0;
    logic                 w_v1;

    // Ready comes from the state register only, never from IN_VALID.
    assign w_ready  = (r_state == RUN);
    assign w_accept = bus.IN_VALID & w_ready;
    assign w_last   = w_accept & (r_cnt == c_last_idx);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_cnt <= '0;
        end else if (r_state == DONE) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

    // FRAME_DONE is registered off DONE, so it lands the cycle after the
    // last RGB pair while the FSM is already back in IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == DONE);
        end
    end

    inv_rct_pixel u_pix0 (
        .clk       (HCLK),
        .rst       (HRESET),
        .in_valid  (w_accept),
        .y         (bus.Y0),
        .cb        (bus.CB0),
        .cr        (bus.CR0),
        .out_valid (w_v0),
        .r         (bus.DATA_RECON_R0),
        .g         (bus.DATA_RECON_G0),
        .b         (bus.DATA_RECON_B0)
    );

    inv_rct_pixel u_pix1 (
        .clk       (HCLK),
        .rst       (HRESET),
        .in_valid  (w_accept),
        .y         (bus.Y1),
        .cb        (bus.CB1),
        .cr        (bus.CR1),
        .out_valid (w_v1),
        .r         (bus.DATA_RECON_R1),
        .g         (bus.DATA_RECON_G1),
        .b         (bus.DATA_RECON_B1)
    );

    assign bus.IN_READY    = w_ready;
    assign bus.RECON_VALID = w_v0 & w_v1;
    assign bus.FRAME_DONE  = r_frame_done;
    // BUSY stays up through the FRAME_DONE cycle so a frame is not reported
    // idle before its completion pulse has been seen.
    assign bus.BUSY        = (r_state != IDLE) | r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_inv_rct_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_rct_stream
//  Purpose  : Self-checking bench for inv_rct_stream with a 4x2 frame
//             (4 pairs). A timeline model predicts IN_READY, BUSY,
//             FRAME_DONE, RECON_VALID and RGB data every cycle.
//  Options  : INV_RCT_CLAMP_EN - must match the DUT build
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_rct_stream;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int PAIRS = W * H / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_rct_stream_if bus();

    inv_rct_stream #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int sx9(input logic [8:0] v);
        return v[8] ? int'(v) - 512 : int'(v);
    endfunction

    function automatic int floor_div4(input int s);
        return (s >= 0) ? s / 4 : -((-s + 3) / 4);
    endfunction

    function automatic int red8(input int v);
`ifdef INV_RCT_CLAMP_EN
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
`else
        return v & 255;
`endif
    endfunction

    function automatic logic [23:0] ref_pix(input int y, input int cb, input int cr);
        int gg, rr, bb;
        gg = y - floor_div4(cb + cr);
        rr = cr + gg;
        bb = cb + gg;
        return {8'(red8(rr)), 8'(red8(gg)), 8'(red8(bb))};
    endfunction

    // ---------------- timeline model + compare ----------------
    typedef struct {
        int          due;
        logic [47:0] d;
    } exp_t;
    exp_t        q[$];
    bit          m_run     = 1'b0;
    int          last_c    = -100;
    int          m_cnt     = 0;
    int          recon_cnt = 0;
    logic [47:0] last_out  = '0;
    bit          started   = 1'b0;

    always @(negedge clk) begin : mon
        int          c;
        bit          ev;
        logic [47:0] act;
        exp_t        e;
        c = cyc;
        if (started) begin
            chk("in_ready", bus.IN_READY, m_run);
            chk("busy", bus.BUSY, m_run || (c > last_c && c <= last_c + 3));
            chk("frame_done", bus.FRAME_DONE, c == last_c + 3);
            ev = (q.size() > 0) && (q[0].due == c);
            chk("recon_valid", bus.RECON_VALID, ev);
            if (ev) begin
                last_out = q[0].d;
                void'(q.pop_front());
            end
            act = {bus.DATA_RECON_R0, bus.DATA_RECON_G0, bus.DATA_RECON_B0,
                   bus.DATA_RECON_R1, bus.DATA_RECON_G1, bus.DATA_RECON_B1};
            chk("rgb_data", act, last_out);
            if (bus.RECON_VALID) recon_cnt++;
            if (c == last_c + 3) begin
                chk("pairs_per_frame", recon_cnt, PAIRS);
                recon_cnt = 0;
            end
        end
        // model advance for the coming edge
        if (rst) begin
            started   = 1'b1;
            m_run     = 1'b0;
            q.delete();
            last_c    = -100;
            m_cnt     = 0;
            recon_cnt = 0;
            last_out  = '0;
        end else if (m_run) begin
            if (bus.IN_VALID) begin
                e.due = c + 2;
                e.d   = {ref_pix(int'(bus.Y0), sx9(bus.CB0), sx9(bus.CR0)),
                         ref_pix(int'(bus.Y1), sx9(bus.CB1), sx9(bus.CR1))};
                q.push_back(e);
                m_cnt++;
                if (m_cnt == PAIRS) begin
                    m_cnt  = 0;
                    last_c = c;
                    m_run  = 1'b0;
                end
            end
        end else if (bus.START && c >= last_c + 3) begin
            m_run = 1'b1;
        end
    end

    // ---------------- driver ----------------
    logic [7:0] n_y0, n_y1;
    logic [8:0] n_cb0, n_cr0, n_cb1, n_cr1;

    task automatic step(input bit st, input bit v, input bit r, output bit acc);
        @(posedge clk);
        #1;
        rst          = r;
        bus.START    = st;
        bus.IN_VALID = v;
        bus.Y0 = n_y0;  bus.CB0 = n_cb0;  bus.CR0 = n_cr0;
        bus.Y1 = n_y1;  bus.CB1 = n_cb1;  bus.CR1 = n_cr1;
        @(negedge clk);
        acc = bus.IN_VALID && bus.IN_READY && !rst;
    endtask

    task automatic set_pair(input int y0, input int cb0, input int cr0,
                            input int y1, input int cb1, input int cr1);
        n_y0 = 8'(y0);  n_cb0 = 9'(cb0);  n_cr0 = 9'(cr0);
        n_y1 = 8'(y1);  n_cb1 = 9'(cb1);  n_cr1 = 9'(cr1);
    endtask

    task automatic rand_pair();
        set_pair($urandom_range(0, 255),
                 int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255,
                 $urandom_range(0, 255),
                 int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic rand_frame(input bit mid_start);
        bit a;
        int idx, g;
        idx = 0;
        g   = 0;
        while (idx < PAIRS && g < 100) begin
            rand_pair();
            step(mid_start && (g == 1), 1'($urandom_range(0, 1)), 1'b0, a);
            if (a) idx++;
            g++;
        end
        chk("frame_accepts", idx, PAIRS);
    endtask

    // START held from the end of a frame until IN_READY rises.
    task automatic rearm();
        bit a, got;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, a);
            got = bus.IN_READY;
        end
        chk("rearm_ready", got, 1);
    endtask

    initial begin : stim
        bit a;
        int idx, g;
        bus.START = 1'b0;
        bus.IN_VALID = 1'b0;
        set_pair(0, 0, 0, 0, 0, 0);
        bus.Y0 = '0; bus.CB0 = '0; bus.CR0 = '0;
        bus.Y1 = '0; bus.CB1 = '0; bus.CR1 = '0;

        // pin the reference arithmetic with hand-computed values
        chk("model_grey",  ref_pix(128, 0, 0), 24'h808080);
        chk("model_red",   ref_pix(63, 0, 255), 24'hFF0000);
        chk("model_green", ref_pix(127, -255, -255), 24'h00FF00);
`ifdef INV_RCT_CLAMP_EN
        chk("model_sat",   ref_pix(255, 255, 255), 24'hFF80FF);
        chk("model_neg",   ref_pix(0, -255, 255), 24'hFF0000);
`else
        chk("model_sat",   ref_pix(255, 255, 255), 24'h7F807F);
        chk("model_neg",   ref_pix(0, -255, 255), 24'hFF0001);
`endif

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, a);
        step(1'b0, 1'b0, 1'b0, a);
        chk("reset_outputs",
            {bus.IN_READY, bus.RECON_VALID, bus.FRAME_DONE, bus.BUSY,
             bus.DATA_RECON_R0, bus.DATA_RECON_G0, bus.DATA_RECON_B0,
             bus.DATA_RECON_R1, bus.DATA_RECON_G1, bus.DATA_RECON_B1}, 0);

        // directed frame: IN_VALID held 6 cycles
        step(1'b1, 1'b0, 1'b0, a);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            case (idx)
                0:       set_pair(128, 0, 0, 128, 0, 0);
                1:       set_pair(63, 0, 255, 127, -255, -255);
                2:       set_pair(255, 255, 255, 255, 255, 255);
                default: set_pair(0, -255, 255, 200, 100, -37);
            endcase
            step(1'b0, 1'b1, 1'b0, a);
            if (a) idx++;
        end
        chk("directed_accepts", idx, PAIRS);
        idle(6);

        // random valid pattern with a mid-frame START, then earliest re-arm
        step(1'b1, 1'b0, 1'b0, a);
        rand_frame(1'b1);
        rearm();
        rand_frame(1'b0);
        idle(6);

        // reset after 2 of 4 pairs
        step(1'b1, 1'b0, 1'b0, a);
        idx = 0;
        g   = 0;
        while (idx < 2 && g < 50) begin
            rand_pair();
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, a);
            if (a) idx++;
            g++;
        end
        chk("abort_accepts", idx, 2);
        step(1'b0, 1'b0, 1'b1, a);
        step(1'b0, 1'b0, 1'b0, a);
        chk("abort_outputs",
            {bus.IN_READY, bus.RECON_VALID, bus.FRAME_DONE, bus.BUSY,
             bus.DATA_RECON_R0, bus.DATA_RECON_G0, bus.DATA_RECON_B0,
             bus.DATA_RECON_R1, bus.DATA_RECON_G1, bus.DATA_RECON_B1}, 0);
        idle(6);

        // full frame after abort, then back-to-back frames
        step(1'b1, 1'b0, 1'b0, a);
        rand_frame(1'b0);
        for (int k = 0; k < 3; k++) begin
            rearm();
            rand_frame(1'b0);
        end
        idle(8);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
